// File: rtl/adc_rx_if.sv
// rtl/adc_rx_if.sv - PCM input stream and register bus bundle for adc_rx
interface adc_rx_if #(
   parameter int CHANNEL = 3
);
   logic [CHANNEL-1:0]    adc_pcm_in_valid;
   logic [CHANNEL-1:0]    adc_pcm_in_ready;
   logic [16*CHANNEL-1:0] adc_pcm_in;
   logic [15:0]           reg_addr;
   logic                  reg_rd;
   logic                  reg_wr;
   logic                  reg_ready;
   logic [31:0]           reg_writedata;
   logic [31:0]           reg_readdata;

   modport master (
      output adc_pcm_in_valid, adc_pcm_in, reg_addr, reg_rd, reg_wr, reg_writedata,
      input  adc_pcm_in_ready, reg_ready, reg_readdata
   );

   modport slave (
      input  adc_pcm_in_valid, adc_pcm_in, reg_addr, reg_rd, reg_wr, reg_writedata,
      output adc_pcm_in_ready, reg_ready, reg_readdata
   );
endinterface

// File: rtl/adc_rx.sv
// rtl/adc_rx.sv - per-channel integrate-and-dump decimator with capture memory
// and register-bus readback of samples and per-channel status.
module adc_rx #(
   parameter int CHANNEL = 3,
   parameter int pcmaw   = 10
) (
   input  logic                     pcm_clk,
   input  logic                     reset_n,
   adc_rx_if.slave                  bus,
   input  logic [pcmaw*CHANNEL-1:0] adc_signal_len,
   input  logic [4*CHANNEL-1:0]     adc_dec_rate,
   input  logic                     adc_run,
   output logic [CHANNEL-1:0]       adc_done
);
   logic run_d;
   logic in_ready;
   logic start;

   assign start = adc_run & ~run_d;

   always_ff @(posedge pcm_clk or negedge reset_n) begin
      if (!reset_n) begin
         run_d    <= 1'b0;
         in_ready <= 1'b0;
      end else begin
         run_d    <= adc_run;
         in_ready <= 1'b1;
      end
   end

   assign bus.adc_pcm_in_ready = {CHANNEL{in_ready}};

   // Zero-extend the address so the channel field stays in range for any pcmaw.
   logic [18:0]      addr_x;
   logic [3:0]       mem_ch;
   logic [3:0]       st_ch;
   logic [pcmaw-1:0] rd_idx;
   logic             unused_bits;

   assign addr_x      = {3'b000, bus.reg_addr};
   assign mem_ch      = addr_x[pcmaw+3:pcmaw];
   assign st_ch       = bus.reg_addr[3:0];
   assign rd_idx      = bus.reg_addr[pcmaw-1:0];
   assign unused_bits = ^{bus.reg_writedata, addr_x};

   logic signed [15:0] rd_q   [CHANNEL];
   logic [pcmaw:0]     wptr_a [CHANNEL];
   logic [CHANNEL-1:0] done_v;

   assign adc_done = done_v;

   for (genvar k = 0; k < CHANNEL; k++) begin : g_ch
      logic signed [23:0] acc;
      logic [7:0]         phase;
      logic [3:0]         rate_l;
      logic [pcmaw:0]     wptr;
      logic               done;
      logic [3:0]         rate_in;
      logic [3:0]         rate_c;
      logic [3:0]         r_eff;
      logic [7:0]         n_m1;
      logic               last;
      logic signed [15:0] sample;
      logic signed [23:0] sum;
      logic signed [23:0] shifted;
      logic [pcmaw-1:0]   len_raw;
      logic [pcmaw:0]     len_eff;
      logic [pcmaw:0]     wptr_nx;
      logic               take;
      logic signed [15:0] mem [2**pcmaw];
      logic signed [15:0] rd_l;

      assign rate_in = adc_dec_rate[4*k +: 4];
      assign rate_c  = (rate_in > 4'd8) ? 4'd8 : rate_in;
      // A new rate is only sampled at the start of an integration window.
      assign r_eff   = (phase == 8'd0) ? rate_c : rate_l;
      assign n_m1    = 8'((9'd1 << r_eff) - 9'd1);
      assign last    = (phase == n_m1);
      assign sample  = bus.adc_pcm_in[16*k +: 16];
      assign sum     = acc + {{8{sample[15]}}, sample};
      assign shifted = sum >>> r_eff;
      assign len_raw = adc_signal_len[pcmaw*k +: pcmaw];
      assign len_eff = (len_raw == '0) ? {1'b1, {pcmaw{1'b0}}} : {1'b0, len_raw};
      assign wptr_nx = wptr + {{pcmaw{1'b0}}, 1'b1};
      assign take    = bus.adc_pcm_in_valid[k] & in_ready & adc_run & ~done & ~start;

      always_ff @(posedge pcm_clk or negedge reset_n) begin
         if (!reset_n) begin
            acc    <= '0;
            phase  <= '0;
            rate_l <= '0;
            wptr   <= '0;
            done   <= 1'b0;
         end else if (start) begin
            acc    <= '0;
            phase  <= '0;
            wptr   <= '0;
            done   <= 1'b0;
         end else if (take) begin
            if (phase == 8'd0)
               rate_l <= rate_c;
            if (last) begin
               acc   <= '0;
               phase <= '0;
               wptr  <= wptr_nx;
               if (wptr_nx == len_eff)
                  done <= 1'b1;
            end else begin
               acc   <= sum;
               phase <= phase + 8'd1;
            end
         end
      end

      // Read and write on the same edge: the read sees the old contents.
      always_ff @(posedge pcm_clk) begin
         if (take && last)
            mem[wptr[pcmaw-1:0]] <= shifted[15:0];
         if (bus.reg_rd)
            rd_l <= mem[rd_idx];
      end

      assign rd_q[k]   = rd_l;
      assign wptr_a[k] = wptr;
      assign done_v[k] = done;
   end

   logic               st_done;
   logic [pcmaw:0]     st_wptr;
   logic [31:0]        st_val;
   logic [3:0]         mem_ch_q;
   logic signed [15:0] m_sel;

   always_comb begin
      st_done = 1'b0;
      st_wptr = '0;
      m_sel   = '0;
      for (int i = 0; i < CHANNEL; i++) begin
         if (st_ch == 4'(i)) begin
            st_done = done_v[i];
            st_wptr = wptr_a[i];
         end
         if (mem_ch_q == 4'(i))
            m_sel = rd_q[i];
      end
   end

   assign st_val = {st_done, 15'b0, 16'(st_wptr)};

   logic        reg_ready_q;
   logic        mem_v;
   logic [31:0] stat_q;

   always_ff @(posedge pcm_clk or negedge reset_n) begin
      if (!reset_n) begin
         reg_ready_q <= 1'b0;
         mem_v       <= 1'b0;
         mem_ch_q    <= '0;
         stat_q      <= '0;
      end else begin
         reg_ready_q <= bus.reg_rd | bus.reg_wr;
         mem_v       <= bus.reg_rd & ~bus.reg_addr[15] & ({1'b0, mem_ch} < 5'(CHANNEL));
         mem_ch_q    <= mem_ch;
         stat_q      <= (bus.reg_rd && bus.reg_addr[15] && ({1'b0, st_ch} < 5'(CHANNEL)))
                        ? st_val : 32'd0;
      end
   end

   assign bus.reg_ready    = reg_ready_q;
   assign bus.reg_readdata = mem_v ? {{16{m_sel[15]}}, m_sel} : stat_q;
endmodule

// File: tb/tb_adc_rx.sv
// tb/tb_adc_rx.sv - directed vector bench for adc_rx with CHANNEL=3, pcmaw=4
module tb_adc_rx;
   localparam int CH = 3;
   localparam int AW = 4;

   logic              pcm_clk = 1'b0;
   logic              reset_n;
   logic [AW*CH-1:0]  sig_len;
   logic [4*CH-1:0]   dec_rate;
   logic              adc_run;
   logic [CH-1:0]     adc_done;

   adc_rx_if #(.CHANNEL(CH)) bus ();

   adc_rx #(.CHANNEL(CH), .pcmaw(AW)) dut (
      .pcm_clk        (pcm_clk),
      .reset_n        (reset_n),
      .bus            (bus),
      .adc_signal_len (sig_len),
      .adc_dec_rate   (dec_rate),
      .adc_run        (adc_run),
      .adc_done       (adc_done)
   );

   always #5 pcm_clk = ~pcm_clk;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      string       name;
      logic [15:0] addr;
      logic [31:0] exp;
   } rd_vec_t;

   rd_vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Drive a one-cycle read at a falling edge and sample the response one cycle later.
   task automatic rd(input logic [15:0] a, output logic [31:0] d, output logic rdy);
      bus.reg_addr = a;
      bus.reg_rd   = 1'b1;
      @(negedge pcm_clk);
      bus.reg_rd   = 1'b0;
      d   = bus.reg_readdata;
      rdy = bus.reg_ready;
   endtask

   task automatic run_table();
      logic [31:0] d;
      logic        rdy;
      foreach (tbl[i]) begin
         rd(tbl[i].addr, d, rdy);
         check({tbl[i].name, "_rdy"}, {31'd0, rdy}, 32'd1);
         check(tbl[i].name, d, tbl[i].exp);
      end
      tbl.delete();
   endtask

   task automatic push(input int ch, input logic [15:0] v);
      bus.adc_pcm_in[16*ch +: 16] = v;
      bus.adc_pcm_in_valid[ch]    = 1'b1;
      @(negedge pcm_clk);
      bus.adc_pcm_in_valid        = '0;
   endtask

   task automatic push12(input logic [15:0] v1, input logic [15:0] v2);
      bus.adc_pcm_in[31:16] = v1;
      bus.adc_pcm_in[47:32] = v2;
      bus.adc_pcm_in_valid  = 3'b110;
      @(negedge pcm_clk);
      bus.adc_pcm_in_valid  = '0;
   endtask

   task automatic cfg(input int ch, input logic [3:0] rate, input logic [3:0] len);
      dec_rate[4*ch +: 4] = rate;
      sig_len[AW*ch +: AW] = len;
   endtask

   task automatic restart();
      adc_run = 1'b0;
      @(negedge pcm_clk);
      adc_run = 1'b1;
      @(negedge pcm_clk);
   endtask

   logic [31:0] d, d2;
   logic        rdy, rdy2;

   initial begin
      reset_n              = 1'b0;
      adc_run              = 1'b0;
      sig_len              = '0;
      dec_rate             = '0;
      bus.adc_pcm_in_valid = '0;
      bus.adc_pcm_in       = '0;
      bus.reg_addr         = '0;
      bus.reg_rd           = 1'b0;
      bus.reg_wr           = 1'b0;
      bus.reg_writedata    = '0;

      // Reset values
      repeat (3) @(negedge pcm_clk);
      check("rst_ready", {29'd0, bus.adc_pcm_in_ready}, 32'd0);
      check("rst_done", {29'd0, adc_done}, 32'd0);
      check("rst_reg_ready", {31'd0, bus.reg_ready}, 32'd0);
      check("rst_readdata", bus.reg_readdata, 32'd0);
      reset_n = 1'b1;
      @(negedge pcm_clk);
      check("ready_after_rst", {29'd0, bus.adc_pcm_in_ready}, 32'd7);
      rd(16'h8000, d, rdy);
      check("rst_status_ch0", d, 32'h0000_0000);

      // Rate 0 passthrough
      cfg(0, 4'd0, 4'd4);
      restart();
      push(0, 16'd1);
      push(0, 16'hFFFE);
      push(0, 16'd3);
      check("r0_done_early", {29'd0, adc_done}, 32'd0);
      push(0, 16'hFFFC);
      check("r0_done", {29'd0, adc_done}, 32'd1);
      tbl.push_back('{"r0_m0", 16'h0000, 32'h0000_0001});
      tbl.push_back('{"r0_m1", 16'h0001, 32'hFFFF_FFFE});
      tbl.push_back('{"r0_m2", 16'h0002, 32'h0000_0003});
      tbl.push_back('{"r0_m3", 16'h0003, 32'hFFFF_FFFC});
      tbl.push_back('{"r0_st", 16'h8000, 32'h8000_0004});
      run_table();

      // Decimate by 4
      cfg(0, 4'd2, 4'd2);
      restart();
      push(0, 16'd4);
      push(0, 16'd4);
      push(0, 16'd4);
      push(0, 16'd8);
      for (int i = 0; i < 3; i++) push(0, 16'hFFFC);
      check("r2_done_early", {29'd0, adc_done}, 32'd0);
      push(0, 16'hFFFC);
      check("r2_done", {29'd0, adc_done}, 32'd1);
      push(0, 16'd100);
      push(0, 16'd100);
      tbl.push_back('{"r2_m0", 16'h0000, 32'h0000_0005});
      tbl.push_back('{"r2_m1", 16'h0001, 32'hFFFF_FFFC});
      tbl.push_back('{"r2_st", 16'h8000, 32'h8000_0002});
      run_table();

      // Full depth on ch1, short decimated capture on ch2
      cfg(1, 4'd0, 4'd0);
      cfg(2, 4'd1, 4'd3);
      restart();
      for (int i = 0; i < 6; i++) push12(16'(i), 16'(2 * i + 1));
      check("fd_ch2_done", {29'd0, adc_done}, 32'b100);
      for (int i = 6; i < 16; i++) push12(16'(i), 16'(2 * i + 1));
      check("fd_all_done", {29'd0, adc_done}, 32'b110);
      tbl.push_back('{"fd_st1", 16'h8001, 32'h8000_0010});
      tbl.push_back('{"fd_st2", 16'h8002, 32'h8000_0003});
      tbl.push_back('{"fd_st0", 16'h8000, 32'h0000_0000});
      tbl.push_back('{"fd_c1m0", 16'h0010, 32'h0000_0000});
      tbl.push_back('{"fd_c1m15", 16'h001F, 32'h0000_000F});
      tbl.push_back('{"fd_c2m0", 16'h0020, 32'h0000_0002});
      tbl.push_back('{"fd_c2m1", 16'h0021, 32'h0000_0006});
      tbl.push_back('{"fd_c2m2", 16'h0022, 32'h0000_000A});
      run_table();

      // Pause and restart
      cfg(0, 4'd0, 4'd4);
      restart();
      push(0, 16'd10);
      push(0, 16'd11);
      adc_run = 1'b0;
      push(0, 16'd99);
      push(0, 16'd98);
      rd(16'h8000, d, rdy);
      check("pause_wptr", d, 32'h0000_0002);
      adc_run = 1'b1;
      @(negedge pcm_clk);
      rd(16'h8000, d, rdy);
      check("restart_wptr", d, 32'h0000_0000);
      for (int i = 0; i < 4; i++) push(0, 16'(20 + i));
      tbl.push_back('{"rs_m0", 16'h0000, 32'h0000_0014});
      tbl.push_back('{"rs_m1", 16'h0001, 32'h0000_0015});
      tbl.push_back('{"rs_m2", 16'h0002, 32'h0000_0016});
      tbl.push_back('{"rs_m3", 16'h0003, 32'h0000_0017});
      tbl.push_back('{"rs_st", 16'h8000, 32'h8000_0004});
      run_table();

      // Back-to-back reads
      bus.reg_addr = 16'h0001;
      bus.reg_rd   = 1'b1;
      @(negedge pcm_clk);
      d = bus.reg_readdata;
      rdy = bus.reg_ready;
      bus.reg_addr = 16'h001F;
      @(negedge pcm_clk);
      bus.reg_rd = 1'b0;
      d2 = bus.reg_readdata;
      rdy2 = bus.reg_ready;
      check("b2b_rdy0", {31'd0, rdy}, 32'd1);
      check("b2b_d0", d, 32'h0000_0015);
      check("b2b_rdy1", {31'd0, rdy2}, 32'd1);
      check("b2b_d1", d2, 32'h0000_000F);
      @(negedge pcm_clk);
      check("b2b_idle_rdy", {31'd0, bus.reg_ready}, 32'd0);
      check("b2b_idle_data", bus.reg_readdata, 32'd0);

      // Write: pulse only, no side effect
      bus.reg_addr      = 16'h0000;
      bus.reg_writedata = 32'hDEAD_BEEF;
      bus.reg_wr        = 1'b1;
      @(negedge pcm_clk);
      bus.reg_wr = 1'b0;
      check("wr_rdy", {31'd0, bus.reg_ready}, 32'd1);
      @(negedge pcm_clk);
      check("wr_rdy_off", {31'd0, bus.reg_ready}, 32'd0);
      tbl.push_back('{"wr_mem_kept", 16'h0000, 32'h0000_0014});
      tbl.push_back('{"inv_mem_ch", 16'h0050, 32'h0000_0000});
      tbl.push_back('{"inv_st_ch", 16'h8007, 32'h0000_0000});
      run_table();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
